fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage. Holds the PC, issues 64-bit read requests to the
//  instruction cache over its AR/R channel, and splits each 64-bit beat into two
//  32-bit instructions. Instructions are buffered in a fetch queue and presented
//  two-wide to decode. Handles PC redirects from branch resolution: flushes the
//  queue and discards the stale in-flight response.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded at reset; bits [1:0] must be 0
//  FQ_DEPTH   4              fetch-queue entries (32-bit instr + PC); power of 2, >=2
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  arvalid        out  1   read-address valid
//  araddr         out  32  fetch address (4-byte aligned)
//  arburst        out  2   constant 2'b01 (INCR)
//  arsize         out  3   constant 3'b011 (8 bytes)
//  arlen          out  8   constant 8'd0 (single beat)
//  arready        in   1   cache accepts address
//  rvalid         in   1   read data valid
//  rdata          in   64  [31:0]=instr @araddr, [63:32]=instr @araddr+4
//  rlast          in   1   last beat (always 1 for arlen=0)
//  rready         out  1   data accept
//  redirect_valid in   1   load new PC; flush
//  redirect_pc    in   32  redirect target; bits [1:0] ignored (treated as 0)
//  dec_valid0     out  1   queue head valid
//  dec_inst0      out  32  head instruction
//  dec_pc0        out  32  head PC
//  dec_valid1     out  1   second entry valid
//  dec_inst1      out  32  second instruction
//  dec_pc1        out  32  second PC
//  dec_accept     in   2   entries consumed this cycle: 0, 1 or 2
// BEHAVIOUR
//  Reset: arvalid=0, araddr=RESET_PC, rready=1, queue empty
//  (dec_valid0/1=0), fetch_pc=RESET_PC, outstanding=0, discard=0.
//  Issue: assert arvalid when !outstanding && free slots (FQ_DEPTH-count) >= 2,
//  evaluated on registered count. Hold arvalid and araddr stable until arready.
//  On AR handshake: outstanding<=1, fetch_pc<=fetch_pc+8 (32-bit wrap).
//  Response: rready held 1 (space reserved at issue). On rvalid&rready&rlast:
//  outstanding<=0; unless discard, push rdata[31:0] (PC=req addr), then
//  rdata[63:32] (PC=req addr+4). Next arvalid no earlier than the following cycle.
//  Queue: dec_valid0 = count>=1; dec_valid1 = count>=2. Entries leave in order.
//  dec_accept > number valid is clamped to number valid.
//  Push and pop in the same cycle: count <= count + pushed - popped.
//  Redirect (highest priority):
//   - queue cleared; fetch_pc <= {redirect_pc[31:2],2'b00}.
//   - if AR already accepted and R not yet seen -> discard<=1; the response is
//     consumed (rready=1) and dropped, then discard<=0.
//   - if arvalid is pending unaccepted -> keep arvalid/araddr until handshake,
//     then treat as discarded.
//   - R handshake in the same cycle as redirect -> data dropped, discard not set.
//   - redirect beats dec_accept and push in the same cycle.
//   - a second redirect while discard=1 only updates fetch_pc.
//  A new request for the redirect target issues only after the stale
//  transaction completes (single outstanding).
//  Reset mid-transaction: everything returns to reset state immediately.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (increments on each
//  non-discarded R handshake) and perf_drop_cnt[31:0] (increments on each
//  discarded R handshake). Both reset to 0 and wrap.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, cache always ready, 1-cycle latency, dec_accept=2 -> araddr 0,8,16...;
//    dec_pc0/1 = 0/4, 8/12; instructions match memory.
//  dec_accept=0 -> after 2 beats (4 entries) arvalid stays 0; accept 1 ->
//    still 0 (free=1); accept again -> arvalid reasserts.
//  Redirect to 0x40 while AR accepted and R pending -> stale beat dropped,
//    queue empty, next araddr=0x40, dec_pc0=0x40.
//  Redirect to 0x82 coincident with R handshake -> beat dropped;
//    next araddr=0x80.
//  Hold arready=0 for 5 cycles -> arvalid/araddr stable throughout;
//    with FETCH_PERF_EN, perf counters match beat and drop counts.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding 64-bit AR/R requests split into a two-wide fetch queue.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt beat counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  input  logic        rlast,
  output logic        rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid0,
  output logic [31:0] dec_inst0,
  output logic [31:0] dec_pc0,
  output logic        dec_valid1,
  output logic [31:0] dec_inst1,
  output logic [31:0] dec_pc1,
  input  logic [1:0]  dec_accept
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t     fq [FQ_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [CW-1:0] count, free;
  logic [31:0]   fetch_pc, req_addr;
  logic          arvalid_q, outstanding, discard, stale;
  logic          ar_hs, r_hs, issue, push;
  logic [1:0]    n_valid, pop_n, push_n;

  assign arvalid = arvalid_q;
  assign araddr  = req_addr;
  assign arburst = 2'b01;
  assign arsize  = 3'b011;
  assign arlen   = 8'd0;
  // Space for both halves is reserved before issue, so R is never back-pressured.
  assign rready  = 1'b1;

  assign ar_hs   = arvalid_q & arready;
  assign r_hs    = rvalid & outstanding & rlast;
  assign free    = CW'(FQ_DEPTH) - count;
  assign issue   = !arvalid_q && !outstanding && !redirect_valid && (free >= CW'(2));
  assign push    = r_hs && !discard && !redirect_valid;
  assign push_n  = push ? 2'd2 : 2'd0;
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_ptr1 = wr_ptr + PW'(1);

  always_comb begin
    n_valid = 2'd0;
    if (count >= CW'(2))  n_valid = 2'd2;
    else if (count != '0) n_valid = 2'd1;
    pop_n = 2'd0;
    if (!redirect_valid) pop_n = (dec_accept > n_valid) ? n_valid : dec_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q   <= 1'b0;
      req_addr    <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      if (ar_hs) arvalid_q <= 1'b0;
      else if (issue) begin
        arvalid_q <= 1'b1;
        req_addr  <= fetch_pc;
      end

      if (ar_hs)     outstanding <= 1'b1;
      else if (r_hs) outstanding <= 1'b0;

      if (redirect_valid)        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (ar_hs && !stale)  fetch_pc <= fetch_pc + 32'd8;

      // A redirect that lands while AR is still waiting marks that request stale;
      // its response is discarded once the handshake finally happens.
      if (ar_hs)                          stale <= 1'b0;
      else if (redirect_valid && arvalid_q) stale <= 1'b1;

      if (ar_hs)                              discard <= stale | redirect_valid;
      else if (r_hs)                          discard <= 1'b0;
      else if (redirect_valid && outstanding) discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_n);
      wr_ptr <= wr_ptr + PW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq[wr_ptr]  <= '{inst: rdata[31:0],  pc: req_addr};
      fq[wr_ptr1] <= '{inst: rdata[63:32], pc: req_addr + 32'd4};
    end
  end

  assign dec_valid0 = (count != '0);
  assign dec_valid1 = (count >= CW'(2));
  assign dec_inst0  = fq[rd_ptr].inst;
  assign dec_pc0    = fq[rd_ptr].pc;
  assign dec_inst1  = fq[rd_ptr1].inst;
  assign dec_pc1    = fq[rd_ptr1].pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else if (r_hs) begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      else      perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected AR addresses and decode entries are queued
// by the stimulus; negedge monitors pop and compare as the DUT presents them.
module tb_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        arvalid, rready;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        arready = 1'b1, rvalid = 1'b0, rlast = 1'b1;
  logic [63:0] rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid0, dec_valid1;
  logic [31:0] dec_inst0, dec_pc0, dec_inst1, dec_pc1;
  logic [1:0]  dec_accept = 2'd0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  int checks = 0, errors = 0, ar_cnt = 0, r_cnt = 0, rlat = 0;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_dec[$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .araddr(araddr), .arburst(arburst), .arsize(arsize), .arlen(arlen),
    .arready(arready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid0(dec_valid0), .dec_inst0(dec_inst0), .dec_pc0(dec_pc0),
    .dec_valid1(dec_valid1), .dec_inst1(dec_inst1), .dec_pc1(dec_pc1),
    .dec_accept(dec_accept)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory image: upper half is the complement of the low address bits.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input int c0, input string name);
    int i;
    for (i = 0; i < 40 && ar_cnt == c0; i++) @(posedge clk);
    #1;
    chk(name, 32'(ar_cnt != c0), 32'd1);
  endtask

  // Cache model: one beat per accepted AR after 1+rlat cycles.
  initial begin : cache
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && arvalid && arready) begin
        a = araddr;
        @(posedge clk);
        repeat (rlat) @(posedge clk);
        #1;
        rvalid = 1'b1;
        rdata  = {mem(a + 32'd4), mem(a)};
        @(negedge clk);
        chk("rready", 32'(rready), 32'd1);
        @(posedge clk);
        r_cnt++;
        #1;
        rvalid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : ar_mon
    if (rst_n && arvalid && arready) begin
      if (exp_ar.size() == 0) begin
        checks++; errors++;
        $display("FAIL ar_unexpected actual=%h expected=none", araddr);
      end else chk("araddr", araddr, exp_ar.pop_front());
      ar_cnt++;
    end
  end

  always @(negedge clk) begin : dec_mon
    int n, k;
    logic [31:0] e, pc, ins;
    if (rst_n && !redirect_valid) begin
      n = int'(dec_valid0) + int'(dec_valid1);
      k = (int'(dec_accept) < n) ? int'(dec_accept) : n;
      for (int i = 0; i < k; i++) begin
        pc  = (i == 0) ? dec_pc0 : dec_pc1;
        ins = (i == 0) ? dec_inst0 : dec_inst1;
        if (exp_dec.size() == 0) begin
          checks++; errors++;
          $display("FAIL dec_unexpected actual=%h expected=none", pc);
        end else begin
          e = exp_dec.pop_front();
          chk("dec_pc", pc, e);
          chk("dec_inst", ins, mem(e));
        end
      end
    end
  end

  initial begin : main
    int c0;
    repeat (2) step();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_rready", 32'(rready), 32'd1);
    chk("rst_v0", 32'(dec_valid0), 32'd0);
    chk("rst_v1", 32'(dec_valid1), 32'd0);
    chk("arburst", 32'(arburst), 32'd1);
    chk("arsize", 32'(arsize), 32'd3);
    chk("arlen", 32'(arlen), 32'd0);

    // Fill with no decode consumption: exactly two beats, then stall.
    exp_ar.push_back(32'h0); exp_ar.push_back(32'h8);
    rst_n = 1'b1;
    repeat (20) step();
    chk("full_arvalid", 32'(arvalid), 32'd0);
    chk("full_v1", 32'(dec_valid1), 32'd1);
    chk("fill_ar_count", 32'(exp_ar.size()), 32'd0);
    exp_dec.push_back(32'h0);
    dec_accept = 2'd1; step(); dec_accept = 2'd0;
    repeat (5) begin step(); chk("free1_arvalid", 32'(arvalid), 32'd0); end
    exp_dec.push_back(32'h4); exp_ar.push_back(32'h10);
    c0 = ar_cnt;
    dec_accept = 2'd1; step(); dec_accept = 2'd0;
    wait_ar(c0, "reissue_timeout");
    repeat (10) step();

    // Streaming at full decode rate.
    for (int i = 0; i < 64; i++)  exp_ar.push_back(32'h18 + 32'(8 * i));
    for (int i = 0; i < 128; i++) exp_dec.push_back(32'h8 + 32'(4 * i));
    dec_accept = 2'd2;
    repeat (40) step();
    dec_accept = 2'd0;
    repeat (20) step();
    chk("stream_progress", 32'(exp_dec.size() < 110), 32'd1);

    // Redirect while AR accepted and R pending.
    rlat = 3;
    c0 = ar_cnt;
    dec_accept = 2'd2; step(); dec_accept = 2'd0;
    wait_ar(c0, "d_ar_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_ar.delete(); exp_dec.delete();
    exp_ar.push_back(32'h40); exp_ar.push_back(32'h48);
    for (int i = 0; i < 4; i++) exp_dec.push_back(32'h40 + 32'(4 * i));
    step();
    redirect_valid = 1'b0;
    rlat = 0;
    chk("flush_v0", 32'(dec_valid0), 32'd0);
    repeat (3) begin chk("stale_no_issue", 32'(arvalid), 32'd0); step(); end
    repeat (25) step();
    chk("d_ar_count", 32'(exp_ar.size()), 32'd0);
    chk("d_full", 32'(dec_valid1), 32'd1);

    // Drain with arready low: request must hold steady.
    arready = 1'b0;
    dec_accept = 2'd2; step(); step(); dec_accept = 2'd0;
    step(); step();
    repeat (5) begin
      step();
      chk("hold_arvalid", 32'(arvalid), 32'd1);
      chk("hold_araddr", araddr, 32'h50);
    end
    chk("d_dec_count", 32'(exp_dec.size()), 32'd0);

    // Redirect to misaligned target coincident with R handshake.
    exp_ar.push_back(32'h50);
    c0 = ar_cnt;
    arready = 1'b1;
    wait_ar(c0, "e_ar_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h82;
    exp_ar.push_back(32'h80); exp_ar.push_back(32'h88);
    for (int i = 0; i < 4; i++) exp_dec.push_back(32'h80 + 32'(4 * i));
    step();
    redirect_valid = 1'b0;
    repeat (20) step();
    chk("e_ar_count", 32'(exp_ar.size()), 32'd0);
    chk("e_full", 32'(dec_valid1), 32'd1);
    arready = 1'b0;
    dec_accept = 2'd2; step(); step(); dec_accept = 2'd0;
    step(); step();
    chk("e_dec_count", 32'(exp_dec.size()), 32'd0);
    chk("e_next_araddr", araddr, 32'h90);
    chk("e_next_arvalid", 32'(arvalid), 32'd1);

`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(r_cnt - 2));
    chk("perf_drop", perf_drop_cnt, 32'd2);
`endif

    // Asynchronous reset with a request pending.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_arvalid", 32'(arvalid), 32'd0);
    chk("arst_araddr", araddr, 32'h0);
    chk("arst_v0", 32'(dec_valid0), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
